// File: rtl/sobel_pkg.sv
// Shared mode encodings and datapath width helpers for the Sobel stream engine.
package sobel_pkg;

  localparam logic [1:0] MODE_MAG    = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;
  localparam logic [1:0] MODE_GX     = 2'd2;
  localparam logic [1:0] MODE_PASS   = 2'd3;

  // Signed gradient width: 4*(2^PIX_W-1) plus a sign bit.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  // Unsigned |gx|+|gy| width.
  function automatic int mag_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Simple dual-port line RAM, registered read, read-first on an address collision.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write and registered read share the edge; the read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel engine: two line buffers (one RAM, two lanes), a 3x3
// window, and a single registered result stage with full backpressure.
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = grad_w(PIX_W);
  localparam int MW = mag_w(PIX_W);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic                    acc;
  logic [CW-1:0]           col, eff_col, ncol, raddr;
  logic [RW-1:0]           row, eff_row, nrow;
  logic [1:0]              mode_q;
  logic [PIX_W-1:0]        thresh_q;
  logic [2*PIX_W-1:0]      lb_rd;
  logic [PIX_W-1:0]        win  [3][3];
  logic [PIX_W-1:0]        nwin [3][3];
  logic signed [GW-1:0]    gx, gy;
  logic [GW-1:0]           ax, ay;
  logic [MW-1:0]           mag;
  logic [PIX_W-1:0]        sat, gxs, res;
  logic                    emit;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  // An accepted in_sof is pixel (0,0) regardless of the counters.
  always_comb begin
    eff_col = in_sof ? '0 : col;
    eff_row = in_sof ? '0 : row;
    ncol    = (eff_col == COL_LAST) ? '0 : eff_col + 1'b1;
    nrow    = eff_row;
    if (eff_col == COL_LAST) nrow = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
    // Prefetch the column the next accept will use so sync-read data is ready.
    raddr   = !rstn ? '0 : (acc ? ncol : col);
    emit    = acc && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
  end

  // Raster counters and per-frame mode/threshold latch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      col      <= '0;
      row      <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
    end else if (acc) begin
      col <= ncol;
      row <= nrow;
      if (eff_col == '0 && eff_row == '0) begin
        mode_q   <= mode;
        thresh_q <= thresh;
      end
    end
  end

  // Lane 0 holds the previous row, lane 1 the row before it.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(2*PIX_W), .AW(CW)) u_lb (
    .clk   (clk),
    .we    (acc),
    .waddr (eff_col),
    .wdata ({lb_rd[PIX_W-1:0], in_pixel}),
    .raddr (raddr),
    .rdata (lb_rd)
  );

  // Window after this accept: shift left, new right column from buffers + input.
  always_comb begin
    for (int y = 0; y < 3; y++) begin
      nwin[y][0] = win[y][1];
      nwin[y][1] = win[y][2];
    end
    nwin[0][2] = lb_rd[2*PIX_W-1:PIX_W];
    nwin[1][2] = lb_rd[PIX_W-1:0];
    nwin[2][2] = in_pixel;
  end

  // Window register; contents outside the current frame are never emitted.
  always_ff @(posedge clk) begin
    if (acc) win <= nwin;
  end

  // Gradients, magnitude and output-mode selection on the new window.
  always_comb begin
    gx  = (ext(nwin[0][2]) + (ext(nwin[1][2]) <<< 1) + ext(nwin[2][2]))
        - (ext(nwin[0][0]) + (ext(nwin[1][0]) <<< 1) + ext(nwin[2][0]));
    gy  = (ext(nwin[2][0]) + (ext(nwin[2][1]) <<< 1) + ext(nwin[2][2]))
        - (ext(nwin[0][0]) + (ext(nwin[0][1]) <<< 1) + ext(nwin[0][2]));
    ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = MW'(ax) + MW'(ay);
    sat = (|mag[MW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
    gxs = (|ax[GW-1:PIX_W]) ? '1 : ax[PIX_W-1:0];
    case (mode_q)
      MODE_MAG:    res = sat;
      MODE_THRESH: res = (sat >= thresh_q) ? '1 : '0;
      MODE_GX:     res = gxs;
      MODE_PASS:   res = nwin[1][1];
      default:     res = sat;
    endcase
  end

  // Output register: load on a completing accept, otherwise drain on transfer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= acc && (eff_col == COL_LAST) && (eff_row == ROW_LAST);
      if (emit) begin
        out_valid <= 1'b1;
        out_pixel <= res;
        out_sof   <= (eff_row == RW'(2)) && (eff_col == CW'(2));
        out_eol   <= (eff_col == COL_LAST);
        out_eof   <= (eff_col == COL_LAST) && (eff_row == ROW_LAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Randomized bench for sobel_stream_engine with a behavioural image model.
module tb_sobel_stream_engine;

  localparam int W = 6;
  localparam int H = 5;

  typedef struct {
    logic [7:0] pix;
    bit         sof, eol, eof;
  } res_t;

  logic       clk = 0;
  logic       rstn = 0;
  logic [1:0] mode = 0;
  logic [7:0] thresh = 0;
  logic       in_valid = 0, in_sof = 0, out_ready = 1;
  logic [7:0] in_pixel = 0;
  logic       in_ready, out_valid, out_sof, out_eol, out_eof, frame_done;
  logic [7:0] out_pixel;

  int tests = 0, errors = 0;
  int rdy_mode = 0;

  // model state
  int   img [H][W];
  int   rnd_img [H][W];
  int   mr = 0, mc = 0, lmode = 0, lth = 0;
  bit   fd_exp = 0;
  bit   held_v = 0;
  res_t held;
  res_t expq[$];
  res_t gotq[$];

  sobel_stream_engine #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .thresh(thresh),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sobel result for an accepted pixel at (r,c), straight from the stored image.
  function automatic res_t model_out(input int r, input int c);
    int p [3][3];
    int gx, gy, ax, ay, sat;
    res_t o;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) p[y][x] = img[r-2+y][c-2+x];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
    sat = (ax + ay > 255) ? 255 : ax + ay;
    case (lmode)
      0: o.pix = 8'(sat);
      1: o.pix = (sat >= lth) ? 8'hFF : 8'h00;
      2: o.pix = 8'(ax > 255 ? 255 : ax);
      default: o.pix = 8'(p[1][1]);
    endcase
    o.sof = (r == 2 && c == 2);
    o.eol = (c == W-1);
    o.eof = (c == W-1 && r == H-1);
    return o;
  endfunction

  // Monitor/compare: evaluated mid-cycle, describing what the next edge does.
  always @(negedge clk) begin
    res_t e;
    if (!rstn) begin
      mr = 0; mc = 0; lmode = 0; lth = 0; fd_exp = 0; held_v = 0;
      expq.delete();
    end else begin
      chk("frame_done", frame_done, fd_exp);
      fd_exp = 0;
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_pixel", out_pixel, held.pix);
        chk("hold_flags", {out_sof, out_eol, out_eof}, {held.sof, held.eol, held.eof});
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("spurious_output", 1, 0);
        else begin
          e = expq.pop_front();
          chk("out_pixel", out_pixel, e.pix);
          chk("out_sof", out_sof, e.sof);
          chk("out_eol", out_eol, e.eol);
          chk("out_eof", out_eof, e.eof);
          e.pix = out_pixel; e.sof = out_sof; e.eol = out_eol; e.eof = out_eof;
          gotq.push_back(e);
        end
      end
      held_v = out_valid && !out_ready;
      held.pix = out_pixel; held.sof = out_sof; held.eol = out_eol; held.eof = out_eof;
      if (in_valid && in_ready) begin
        if (in_sof) begin mr = 0; mc = 0; end
        if (mr == 0 && mc == 0) begin lmode = mode; lth = thresh; end
        img[mr][mc] = in_pixel;
        if (mr >= 2 && mc >= 2) expq.push_back(model_out(mr, mc));
        fd_exp = (mr == H-1 && mc == W-1);
        if (mc == W-1) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
        else mc++;
      end
    end
  end

  // Downstream ready: always, the 1,0,0,1 pattern, or random.
  initial begin
    int rc = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1;
        1: begin out_ready = (rc % 4 == 0) || (rc % 4 == 3); rc++; end
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
    case (kind)
      0: return 8'(r*W + c);
      1: return (c < 2) ? 8'h00 : 8'hFF;
      2: return 8'(rnd_img[r][c]);
      default: return (r == 1 && c == 1) ? 8'h5A : 8'((r*W + c) * 9);
    endcase
  endfunction

  task automatic wait_accept();
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin chk("accept_timeout", 1, 0); done = 1; end
    end
  endtask

  task automatic send(input int kind, input int md, input int th, input bit sof,
                      input int npix, input int gap, input bit scramble);
    mode = 2'(md); thresh = 8'(th);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(99) < gap) begin in_valid = 0; @(posedge clk); #1; end
      in_valid = 1;
      in_sof   = sof && (i == 0);
      in_pixel = pix_of(kind, (i / W) % H, i % W);
      wait_accept();
      if (scramble && i == 0) begin mode = 2'($urandom); thresh = 8'($urandom); end
    end
    in_valid = 0; in_sof = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk("drain_timeout", 1, 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic fill_rnd();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) rnd_img[r][c] = $urandom_range(255);
  endtask

  task automatic check_ramp(input string tag);
    chk({tag, "_count"}, gotq.size(), 12);
    for (int i = 0; i < gotq.size(); i++) begin
      chk({tag, "_pix"}, gotq[i].pix, 56);
      chk({tag, "_sof"}, gotq[i].sof, i == 0);
      chk({tag, "_eol"}, gotq[i].eol, i % 4 == 3);
      chk({tag, "_eof"}, gotq[i].eof, i == 11);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_markers", {out_sof, out_eol, out_eof}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;

    // Ramp, magnitude mode: gx=8, gy=48 everywhere -> 56
    gotq.delete();
    send(0, 0, 0, 1, W*H, 0, 0);
    drain();
    check_ramp("ramp");

    // Vertical edge, threshold mode
    gotq.delete();
    send(1, 1, 100, 1, W*H, 0, 0);
    drain();
    chk("edge_count", gotq.size(), 12);
    for (int i = 0; i < gotq.size(); i++)
      chk("edge_thr100", gotq[i].pix, (i % 4 < 2) ? 255 : 0);
    gotq.delete();
    send(1, 1, 0, 1, W*H, 0, 0);
    drain();
    chk("edge0_count", gotq.size(), 12);
    for (int i = 0; i < gotq.size(); i++) chk("edge_thr0", gotq[i].pix, 255);

    // Ramp again under backpressure pattern and input gaps
    rdy_mode = 1;
    gotq.delete();
    send(0, 0, 0, 1, W*H, 30, 0);
    drain();
    check_ramp("ramp_bp");
    rdy_mode = 0;

    // Pass-through mode, first centre is 0x5A; mode changes mid-frame ignored
    gotq.delete();
    send(3, 3, 0, 1, W*H, 0, 1);
    drain();
    chk("pass_count", gotq.size(), 12);
    if (gotq.size() > 0) chk("pass_first", gotq[0].pix, 8'h5A);

    // Reset after a partial frame with one result already pending
    gotq.delete();
    send(2, 2, 0, 1, 15, 0, 0);
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    send(0, 0, 0, 0, W*H, 0, 0);
    drain();
    check_ramp("after_rst");

    // Resync: partial frame abandoned by a fresh in_sof
    fill_rnd();
    gotq.delete();
    send(2, 2, 0, 1, 9, 0, 0);
    send(0, 0, 0, 1, W*H, 0, 0);
    drain();
    check_ramp("resync");

    // Randomized frames: image, mode, gaps, backpressure, optional sof
    for (int f = 0; f < 8; f++) begin
      fill_rnd();
      rdy_mode = $urandom_range(2);
      send($urandom_range(3), $urandom_range(3), $urandom_range(255), f % 2 == 0,
           W*H, $urandom_range(40), 1);
    end
    drain();
    rdy_mode = 0;
    chk("final_queue_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
